// File: rtl/game_sequencer.sv
// game_sequencer: button-driven controller that sequences the game engine, runs the skip timer, tracks the high score and supplies random bits
module game_sequencer #(
    parameter logic [25:0] PERIOD_BASE = 26'd50_000_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BtnC,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       q_I,
    input  logic       q_Play,
    input  logic       q_Done,
    input  logic [6:0] score,
    output logic       Start,
    output logic       Ack,
    output logic       Pulse,
    output logic       LEFT_Btn,
    output logic       RIGHT_Btn,
    output logic       rand_bit,
    output logic [1:0] level,
    output logic [6:0] high_score
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_END  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [25:0] cnt_q, cnt_d, period_m1;
    logic [15:0] lfsr_q, lfsr_d;
    logic [2:0]  btn_q, btn_d;
    logic [1:0]  level_q, level_d;
    logic [6:0]  high_q, high_d;
    logic        start_q, start_d, ack_q, ack_d, pulse_q, pulse_d;
    logic        left_q, left_d, right_q, right_d, seen_q, seen_d;
    logic        edge_c, edge_l, edge_r;

    assign Start      = start_q;
    assign Ack        = ack_q;
    assign Pulse      = pulse_q;
    assign LEFT_Btn   = left_q;
    assign RIGHT_Btn  = right_q;
    assign rand_bit   = lfsr_q[0];
    assign level      = level_q;
    assign high_score = high_q;

    // Edge detection, timer period, controller transitions and strobe generation
    always_comb begin
        btn_d     = {BtnR, BtnL, BtnC};
        edge_c    = BtnC & ~btn_q[0];
        edge_l    = BtnL & ~btn_q[1];
        edge_r    = BtnR & ~btn_q[2];
        level_d   = score[6] ? 2'd3 : score[5:4];
        period_m1 = (PERIOD_BASE >> level_q) - 26'd1;
        lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        seen_d    = (state_q == S_WAIT) & (seen_q | ~q_Play);
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        ack_d     = 1'b0;
        pulse_d   = 1'b0;
        left_d    = 1'b0;
        right_d   = 1'b0;
        case (state_q)
            S_IDLE: if (edge_c && q_I) begin
                start_d = 1'b1;
                state_d = S_ARM;
            end
            S_ARM: if (q_Done) state_d = S_END;
            else if (q_Play) begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
            S_RUN: if (q_Done) state_d = S_END;
            else if (edge_l ^ edge_r) begin
                left_d  = edge_l;
                right_d = edge_r;
                cnt_d   = '0;
                state_d = S_WAIT;
            end else if (!edge_l) begin
                pulse_d = cnt_q >= period_m1;
                cnt_d   = pulse_d ? '0 : cnt_q + 26'd1;
                state_d = pulse_d ? S_WAIT : S_RUN;
            end
            S_WAIT: if (seen_q && q_Done) state_d = S_END;
            else if (seen_q && q_Play) begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
            S_END: if (edge_c) begin
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        high_d = (state_d == S_END && state_q != S_END && score > high_q) ? score : high_q;
    end

    // Registered state and outputs; reset overrides every other event
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            btn_q   <= '0;
            level_q <= '0;
            high_q  <= '0;
            start_q <= 1'b0;
            ack_q   <= 1'b0;
            pulse_q <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            btn_q   <= btn_d;
            level_q <= level_d;
            high_q  <= high_d;
            start_q <= start_d;
            ack_q   <= ack_d;
            pulse_q <= pulse_d;
            left_q  <= left_d;
            right_q <= right_d;
            seen_q  <= seen_d;
        end
    end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter PERIOD_BASE, default 26'd50_000_000: skip-timer period in clocks at level 0.
REQ-002 Parameter LFSR_SEED, default 16'hACE1: LFSR value loaded on reset.
REQ-003 Clk  input  1  system clock; all logic on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 BtnC  input  1  debounced centre button (start/acknowledge), level.
REQ-006 BtnL, BtnR  input  1 each  debounced left/right buttons, level.
REQ-007 q_I, q_Play, q_Done  input  1 each  game engine one-hot state flags.
REQ-008 score  input  7  game engine score.
REQ-009 Start, Ack, Pulse  output  1 each  one-cycle control strobes to the engine.
REQ-010 LEFT_Btn, RIGHT_Btn  output  1 each  one-cycle move strobes to the engine.
REQ-011 rand  output  1  pseudo-random bit to the engine.
REQ-012 level  output  2  current difficulty level.
REQ-013 high_score  output  7  best score since reset.

Function
REQ-014 Every output SHALL be driven from a register; all strobes SHALL be exactly one cycle wide.
REQ-015 Rising edges of BtnC/BtnL/BtnR SHALL be detected against a one-cycle-delayed copy; only edges SHALL count, never held levels.
REQ-016 Controller states SHALL be IDLE, ARM, RUN, WAIT, END.
REQ-017 IDLE: BtnC edge while q_I=1 -> Start=1 for one cycle, go ARM. BtnC edge while q_I=0 SHALL be ignored.
REQ-018 ARM: q_Play=1 -> go RUN with the skip counter cleared.
REQ-019 RUN: BtnL edge alone -> LEFT_Btn=1; BtnR edge alone -> RIGHT_Btn=1; either case -> go WAIT and clear the skip counter.
REQ-020 RUN: BtnL and BtnR edges in the same cycle SHALL issue no strobe; state and counter are unchanged.
REQ-021 RUN: skip counter SHALL increment each cycle. At count = period-1 with no move strobe issued that cycle: Pulse=1, counter clears, go WAIT.
REQ-022 A move strobe SHALL take priority over Pulse in the same cycle.
REQ-023 period SHALL equal PERIOD_BASE >> level (26-bit).
REQ-024 level SHALL equal min(score[6:4], 3); it is recomputed every cycle, registered.
REQ-025 WAIT: after at least one cycle with q_Play=0, q_Play=1 -> RUN and q_Done=1 -> END. Button edges in WAIT SHALL be discarded.
REQ-026 END entry cycle: if score > high_score, high_score <= score; otherwise unchanged.
REQ-027 END: BtnC edge -> Ack=1 for one cycle, go IDLE.
REQ-028 q_Done=1 seen in ARM or RUN SHALL also force END, with the same high_score update.
REQ-029 LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every cycle in all states; rand = lfsr[0].
REQ-030 Illegal controller encoding SHALL recover to IDLE on the next clock.

Reset
REQ-031 Reset=1 at a clock edge SHALL force, in any state:
  - state=IDLE
  - Start, Ack, Pulse, LEFT_Btn, RIGHT_Btn = 0
  - level=0, high_score=0
  - skip counter=0
  - button history=0
  - lfsr=LFSR_SEED
REQ-032 Reset SHALL take priority over every other event, including a simultaneous button edge.
REQ-033 Reset asserted mid-game SHALL discard any pending strobe; no strobe SHALL appear in the cycle after reset.

Verification
REQ-034 PERIOD_BASE=16, q_I=1, BtnC rise -> Start high exactly 1 cycle; q_Play=1 -> RUN.
REQ-035 RUN, score=0, no buttons for 16 cycles -> Pulse on cycle 16, one cycle wide. Repeat with score=48 -> Pulse every 2 cycles.
REQ-036 RUN: BtnL rises in the same cycle the counter hits 15 -> LEFT_Btn=1, Pulse=0, counter=0.
REQ-037 RUN: BtnL and BtnR rise together -> no strobes. BtnL held high 100 cycles -> exactly one LEFT_Btn.
REQ-038 In WAIT, q_Done=1 with score=37 and high_score=20 -> END, high_score=37. Next game ends at score=10 -> high_score stays 37. BtnC -> single Ack, then IDLE.
REQ-039 Reset pulsed in RUN -> all outputs at reset values next cycle; lfsr=16'hACE1; the 16-bit sequence repeats with period 65535.
